gsd_to_bin_serial: RTL and testbench

//  Multi-cycle, handshaked GSD (signed-digit) to two's-complement converter.
//  It is the inverse of the binary-to-GSD path and sits at the output of a
//  GSD adder chain, where results leave the redundant domain.

---
 rtl/gsd_to_bin_serial.sv | 191 +++++++++++++++++++
 tb/tb_gsd_to_bin_serial.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsd_to_bin_serial.sv
// -----------------------------------------------------------------------------
// gsd_to_bin_serial
//
// Multi-cycle, handshaked converter from generalised signed-digit (GSD) form to
// two's complement. Sits at the output of a GSD adder chain, where results
// leave the redundant domain. DPC digits are resolved per cycle, least
// significant digit first, through a serial borrow chain.
//
// Digit encoding (digit i = A[2i+1:2i]):
//   01 = +1, 10 = -1, 00 = 0, 11 = illegal (converted as 0, flagged on ERR)
//
// Parameters
//   LEN  digits in / bits out (LEN >= 2)
//   DPC  digits converted per cycle (LEN % DPC == 0)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A is valid
//   in_ready   block can accept A (high only while idle)
//   A          2*LEN-bit GSD operand
//   out_valid  S/OVF/ERR hold a finished result
//   out_ready  consumer accepts the result
//   S          result, equal to the signed-digit value mod 2^LEN
//   OVF        true value lies outside [-2^(LEN-1), 2^(LEN-1)-1]
//   ERR        at least one digit was 11
//
// Timing: accept edge is cycle 0, out_valid rises after edge LEN/DPC.
// in_ready and out_valid are decoded from the state register only, so there
// is no combinational path from in_valid/out_ready to any output.
// -----------------------------------------------------------------------------
module gsd_to_bin_serial #(
  parameter int unsigned LEN = 8,
  parameter int unsigned DPC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*LEN-1:0] A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   S,
  output logic             OVF,
  output logic             ERR
);

  localparam int unsigned STEPS = LEN / DPC;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Working registers for the conversion in flight
  logic [2*LEN-1:0] r_dig;     // unconsumed digits, lowest at bit 0
  logic [LEN-1:0]   r_res;     // result bits, filled from the top downwards
  logic             r_borrow;  // borrow carried into the next digit
  logic             r_err;     // illegal digit seen so far
  logic [CW-1:0]    r_cnt;     // conversion steps already taken

  // Combinational step results
  logic [DPC-1:0]   w_p;
  logic [DPC-1:0]   w_n;
  logic [DPC-1:0]   w_bits;
  logic             w_b;
  logic             w_err;
  logic [LEN-1:0]   w_res_next;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_step   = (r_state == CONV);
  assign w_last   = w_step && (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = CONV;
        end
      end
      CONV: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Borrow chain over the DPC lowest unconsumed digits.
  // Subtracting the negative digits from the positive ones bit-serially:
  //   s  = p ^ n ^ b
  //   b' = (n & ~p) | (~(p ^ n) & b)
  // An illegal 11 digit decodes as p=n=0, i.e. it contributes nothing.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_p    = '0;
    w_n    = '0;
    w_bits = '0;
    w_b    = r_borrow;
    w_err  = r_err;
    for (int unsigned k = 0; k < DPC; k++) begin
      w_p[k] = (r_dig[2*k +: 2] == 2'b01);
      w_n[k] = (r_dig[2*k +: 2] == 2'b10);
      if (r_dig[2*k +: 2] == 2'b11) begin
        w_err = 1'b1;
      end
      w_bits[k] = w_p[k] ^ w_n[k] ^ w_b;
      w_b       = (w_n[k] & ~w_p[k]) | (~(w_p[k] ^ w_n[k]) & w_b);
    end
  end

  // New bits enter at the top while older ones move down; after STEPS shifts
  // bit i of r_res holds the result bit for digit i. Written as a shift/OR so
  // the DPC == LEN case (single-step conversion) needs no special slicing.
  assign w_res_next = (r_res >> DPC) | (LEN'(w_bits) << (LEN - DPC));

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig    <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      S        <= '0;
      OVF      <= 1'b0;
      ERR      <= 1'b0;
    end else if (w_accept) begin
      r_dig    <= A;
      r_borrow <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_dig    <= r_dig >> (2 * DPC);
      r_res    <= w_res_next;
      r_borrow <= w_b;
      r_err    <= w_err;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        // Final borrow is the sign of the true value; any disagreement with
        // the result's top bit means the value did not fit in LEN bits.
        S   <= w_res_next;
        OVF <= w_res_next[LEN-1] ^ w_b;
        ERR <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_gsd_to_bin_serial.sv
module tb_gsd_to_bin_serial;

  localparam int unsigned LEN   = 8;
  localparam int unsigned DPC   = 2;
  localparam int unsigned STEPS = LEN / DPC;
  localparam int          NRAND = 3000;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2*LEN-1:0] A;
  logic             out_valid;
  logic             out_ready;
  logic [LEN-1:0]   S;
  logic             OVF;
  logic             ERR;

  gsd_to_bin_serial #(.LEN(LEN), .DPC(DPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .OVF       (OVF),
    .ERR       (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Model: value = sum d_i * 2^i as a plain integer
  typedef struct packed {
    logic [LEN-1:0] s;
    logic           ovf;
    logic           err;
  } exp_t;

  function automatic exp_t model(input logic [2*LEN-1:0] a);
    exp_t r;
    int   v;
    logic [1:0] d;
    v     = 0;
    r.err = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      d = a[2*i +: 2];
      if (d == 2'b01) v = v + (1 << i);
      else if (d == 2'b10) v = v - (1 << i);
      else if (d == 2'b11) r.err = 1'b1;
    end
    r.s   = v[LEN-1:0];
    r.ovf = (v > (1 << (LEN-1)) - 1) || (v < -(1 << (LEN-1)));
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: cycle-level expectation of handshake and result outputs
  // ---------------------------------------------------------------------------
  exp_t q[$];
  exp_t last;
  exp_t cur;
  bit   m_pending = 0;
  int   m_age = 0;
  bit   exp_ov;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_pending = 0;
      m_age     = 0;
      last      = '0;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_S", S, 0);
      check("rst_OVF", OVF, 0);
      check("rst_ERR", ERR, 0);
    end else begin
      if (m_pending) m_age++;
      exp_ov = m_pending && (m_age >= STEPS + 1);
      check("out_valid", out_valid, exp_ov);
      check("in_ready", in_ready, !m_pending);
      cur = exp_ov ? q[0] : last;
      check("S", S, cur.s);
      check("OVF", OVF, cur.ovf);
      check("ERR", ERR, cur.err);
      if (exp_ov && out_ready) begin
        last      = q.pop_front();
        m_pending = 0;
      end else if (!m_pending && in_valid) begin
        q.push_back(model(A));
        m_pending = 1;
        m_age     = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [2*LEN-1:0] a);
    int n;
    n        = 0;
    in_valid = 1'b1;
    A        = a;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeout("send_wait");
    @(posedge clk); #1;
    in_valid = 1'b0;
    A        = 16'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) timeout("out_wait");
  endtask

  task automatic directed(input string name, input logic [2*LEN-1:0] a,
                          input logic [LEN-1:0] es, input logic eo, input logic ee);
    exp_t m;
    int   lat;
    m = model(a);
    check({name, "_model_S"}, m.s, es);
    check({name, "_model_OVF"}, m.ovf, eo);
    check({name, "_model_ERR"}, m.err, ee);
    send(a);
    wait_out(lat);
    check({name, "_latency"}, lat, STEPS);
    check({name, "_S"}, S, es);
    check({name, "_OVF"}, OVF, eo);
    check({name, "_ERR"}, ERR, ee);
    @(posedge clk); #1;
  endtask

  function automatic logic [2*LEN-1:0] rand_legal();
    logic [2*LEN-1:0] a;
    int unsigned r;
    a = '0;
    for (int i = 0; i < LEN; i++) begin
      r = $urandom_range(0, 2);
      a[2*i +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
    end
    return a;
  endfunction

  bit rnd_on = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   lat;
    int   n;
    logic [LEN-1:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_S", S, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("zero",    16'h0000, 8'h00, 1'b0, 1'b0);
    directed("mixed",   16'h0061, 8'h05, 1'b0, 1'b0);
    directed("signs",   16'h8000, 8'h80, 1'b0, 1'b0);
    directed("ovf",     16'h4000, 8'h80, 1'b1, 1'b0);
    directed("illegal", 16'h000C, 8'h00, 1'b0, 1'b1);
    directed("errclr",  16'h0061, 8'h05, 1'b0, 1'b0);
    directed("max",     16'h5555, 8'hFF, 1'b1, 1'b0);
    directed("minus1",  16'h0002, 8'hFF, 1'b0, 1'b0);

    // Backpressure in DONE with ignored in_valid pulses
    out_ready = 1'b0;
    send(16'hAAAA);
    wait_out(lat);
    check("bp_latency", lat, STEPS);
    held = S;
    check("bp_S", S, 8'h01);
    check("bp_OVF", OVF, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      A        = 16'h5555;
      @(posedge clk); #1;
      check("bp_hold_S", S, held);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_S_hold", S, 8'h01);

    // Reset while converting (after two steps)
    send(16'h0061);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstconv_out_valid", out_valid, 0);
    check("rstconv_S", S, 0);
    check("rstconv_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstconv_ready_after", in_ready, 1);
    directed("after_rst", 16'h0061, 8'h05, 1'b0, 1'b0);

    // Random legal operands with random gaps and backpressure
    rnd_on = 1;
    for (int i = 0; i < NRAND; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(rand_legal());
    end
    n = 0;
    while ((m_pending || q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_pending || q.size() != 0) timeout("drain");
    rnd_on = 0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
